// File: rtl/sys_defs.sv
// Shared definitions for the rename/freelist slice: sizes, branch tag/mask types
// and the freelist state image exchanged with the checkpoint stack.
`ifndef SYS_DEFS_SV
`define SYS_DEFS_SV

`define FREELIST_FIFO_SIZE 32
`define BSTACK_DEPTH 4

package sys_defs;

    localparam int FL_FIFO_SIZE = `FREELIST_FIFO_SIZE;
    localparam int FL_PTR_W     = $clog2(FL_FIFO_SIZE) + 1;
    localparam int PREG_IDX_W   = 6;
    localparam int BSTACK_DEPTH = `BSTACK_DEPTH;
    localparam int BRANCH_TAG_W = $clog2(BSTACK_DEPTH);

    typedef logic [BRANCH_TAG_W-1:0] BRANCH_TAG;
    typedef logic [BSTACK_DEPTH-1:0] BRANCH_MASK;

    typedef struct packed {
        logic [FL_FIFO_SIZE-1:0][PREG_IDX_W-1:0] free_list;
        logic [FL_PTR_W-1:0]                     read_ptr;
        logic [FL_PTR_W-1:0]                     write_ptr;
    } FREELIST_STATE_PACKET;

endpackage

`endif

// File: rtl/bstack_alloc_sel.sv
// Lowest-zero priority encoder: picks the lowest free checkpoint slot and
// flags whether any slot is free at all.
module bstack_alloc_sel #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] busy,
    output logic [W-1:0] idx,
    output logic         any_free
);

    // NOTE: both outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        idx      = '0;
        any_free = 1'b0;
        // Scan downward so the lowest free index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                idx      = W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fl_checkpoint_stack.sv
// Branch checkpoint stack for the freelist: snapshots the read pointer per branch,
// tracks branch age via dependency masks, and builds the squash restore image.
module fl_checkpoint_stack
    import sys_defs::*;
#(
    parameter int DEPTH     = BSTACK_DEPTH,
    parameter int FIFO_SIZE = FL_FIFO_SIZE
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       br_dispatch,
    input  logic [1:0]                 br_pregs_before,
    input  FREELIST_STATE_PACKET       fl_state_in,
    input  logic                       resolve_valid,
    input  logic [$clog2(DEPTH)-1:0]   resolve_tag,
    input  logic                       resolve_mispredict,
    output logic [$clog2(DEPTH)-1:0]   alloc_tag,
    output logic [DEPTH-1:0]           alloc_mask,
    output logic                       stall,
    output logic                       squash,
    output FREELIST_STATE_PACKET       branch_stack_state,
    output logic [DEPTH-1:0]           kill_mask
);

    localparam int TAG_W = $clog2(DEPTH);
    localparam int PTR_W = $clog2(FIFO_SIZE) + 1;

    logic [DEPTH-1:0] valid, valid_next;
    logic [PTR_W-1:0] rptr [DEPTH];
    logic [PTR_W-1:0] rptr_next [DEPTH];
    logic [DEPTH-1:0] dep [DEPTH];
    logic [DEPTH-1:0] dep_next [DEPTH];

    logic [TAG_W-1:0] free_tag;
    logic             any_free;
    logic             hit, mis_hit, cor_hit, do_alloc;
    logic [DEPTH-1:0] cor_clear, live_after_resolve;
    logic [PTR_W:0]   ptr_sum, ptr_wrap;

    bstack_alloc_sel #(.N(DEPTH)) u_alloc_sel (
        .busy     (valid),
        .idx      (free_tag),
        .any_free (any_free)
    );

    assign hit        = resolve_valid & valid[resolve_tag];
    assign mis_hit    = hit & resolve_mispredict;
    assign cor_hit    = hit & ~resolve_mispredict;
    assign stall      = ~any_free;
    assign alloc_tag  = free_tag;
    assign alloc_mask = valid;
    assign squash     = mis_hit;
    // A mispredict squashes the younger dispatching branch along with everything else.
    assign do_alloc   = br_dispatch & any_free & ~mis_hit;

    always_comb begin
        cor_clear = '0;
        if (cor_hit) cor_clear[resolve_tag] = 1'b1;
        live_after_resolve = valid & ~cor_clear;
    end

    always_comb begin
        kill_mask = '0;
        if (mis_hit) begin
            kill_mask[resolve_tag] = 1'b1;
            for (int j = 0; j < DEPTH; j++) begin
                if (valid[j] && dep[j][resolve_tag]) kill_mask[j] = 1'b1;
            end
        end
    end

    // Only the read side rewinds; retirements feeding the write side are older than the branch.
    always_comb begin
        branch_stack_state = '0;
        if (mis_hit) begin
            branch_stack_state.read_ptr  = FL_PTR_W'(rptr[resolve_tag]);
            branch_stack_state.write_ptr = fl_state_in.write_ptr;
            branch_stack_state.free_list = fl_state_in.free_list;
        end
    end

    always_comb begin
        ptr_sum  = (PTR_W + 1)'(fl_state_in.read_ptr) + (PTR_W + 1)'(br_pregs_before);
        ptr_wrap = (ptr_sum >= (PTR_W + 1)'(FIFO_SIZE)) ? ptr_sum - (PTR_W + 1)'(FIFO_SIZE)
                                                       : ptr_sum;
    end

    always_comb begin
        valid_next = live_after_resolve & ~kill_mask;
        for (int j = 0; j < DEPTH; j++) begin
            dep_next[j]  = dep[j] & ~cor_clear;
            rptr_next[j] = rptr[j];
        end
        if (do_alloc) begin
            valid_next[free_tag] = 1'b1;
            dep_next[free_tag]   = live_after_resolve;
            rptr_next[free_tag]  = ptr_wrap[PTR_W-1:0];
        end
    end

    // NOTE: the checkpoint arrays are tiny flops, so they are cleared on reset rather than left undefined.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                dep[j]  <= '0;
                rptr[j] <= '0;
            end
        end else begin
            valid <= valid_next;
            for (int j = 0; j < DEPTH; j++) begin
                dep[j]  <= dep_next[j];
                rptr[j] <= rptr_next[j];
            end
        end
    end

endmodule

// File: tb/tb_fl_checkpoint_stack.sv
// Scoreboard bench for fl_checkpoint_stack: expectations are queued with each
// stimulus cycle and compared against the outputs mid-cycle.
module tb_fl_checkpoint_stack;
    import sys_defs::*;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 br_dispatch;
    logic [1:0]           br_pregs_before;
    FREELIST_STATE_PACKET fl_state_in;
    logic                 resolve_valid;
    logic [1:0]           resolve_tag;
    logic                 resolve_mispredict;
    logic [1:0]           alloc_tag;
    logic [3:0]           alloc_mask;
    logic                 stall;
    logic                 squash;
    FREELIST_STATE_PACKET branch_stack_state;
    logic [3:0]           kill_mask;

    always #5 clock = ~clock;

    fl_checkpoint_stack #(.DEPTH(4), .FIFO_SIZE(32)) dut (
        .clock              (clock),
        .reset              (reset),
        .br_dispatch        (br_dispatch),
        .br_pregs_before    (br_pregs_before),
        .fl_state_in        (fl_state_in),
        .resolve_valid      (resolve_valid),
        .resolve_tag        (resolve_tag),
        .resolve_mispredict (resolve_mispredict),
        .alloc_tag          (alloc_tag),
        .alloc_mask         (alloc_mask),
        .stall              (stall),
        .squash             (squash),
        .branch_stack_state (branch_stack_state),
        .kill_mask          (kill_mask)
    );

    typedef struct {
        string        tag;
        logic [255:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [FL_PTR_W-1:0]                     cur_w;
    logic [FL_FIFO_SIZE-1:0][PREG_IDX_W-1:0] cur_f;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] observe(input string tag);
        case (tag)
            "squash": return 256'(squash);
            "kill":   return 256'(kill_mask);
            "rptr":   return 256'(branch_stack_state.read_ptr);
            "wptr":   return 256'(branch_stack_state.write_ptr);
            "flist":  return 256'(branch_stack_state.free_list);
            "stall":  return 256'(stall);
            "atag":   return 256'(alloc_tag);
            "amask":  return 256'(alloc_mask);
            default:  return '1;
        endcase
    endfunction

    task automatic push(input string tag, input logic [255:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic exp_state(input logic [3:0] amask, input logic [1:0] atag, input logic st);
        push("amask", 256'(amask));
        push("stall", 256'(st));
        if (!st) push("atag", 256'(atag));
    endtask

    task automatic exp_quiet();
        push("squash", 256'(1'b0));
        push("kill", 256'(4'b0000));
    endtask

    task automatic exp_squash(input logic [3:0] kill, input logic [5:0] rp);
        push("squash", 256'(1'b1));
        push("kill", 256'(kill));
        push("rptr", 256'(rp));
        push("wptr", 256'(cur_w));
        push("flist", 256'(cur_f));
    endtask

    task automatic exp_reset_outputs();
        exp_state(4'b0000, 2'd0, 1'b0);
        exp_quiet();
        push("rptr", 256'(0));
        push("wptr", 256'(0));
        push("flist", 256'(0));
    endtask

    task automatic new_live();
        cur_w = FL_PTR_W'($urandom_range(0, 31));
        for (int i = 0; i < FL_FIFO_SIZE; i++) cur_f[i] = PREG_IDX_W'($urandom);
    endtask

    // Drive one cycle from the falling edge, check queued expectations, advance.
    task automatic step(input logic d, input logic [1:0] p, input logic [5:0] rp,
                        input logic rv, input logic [1:0] t, input logic m);
        exp_t e;
        br_dispatch           = d;
        br_pregs_before       = p;
        fl_state_in.read_ptr  = rp;
        fl_state_in.write_ptr = cur_w;
        fl_state_in.free_list = cur_f;
        resolve_valid         = rv;
        resolve_tag           = t;
        resolve_mispredict    = m;
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.tag), e.val);
        end
        @(negedge clock);
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        new_live();
        @(negedge clock);
        idle();
        exp_reset_outputs();
        idle();
        reset = 1'b0;

        // Pointer wrap: 30 + 3 -> 1, proven by mispredicting the checkpoint.
        exp_state(4'b0000, 2'd0, 1'b0); exp_quiet();
        step(1'b1, 2'd3, 6'd30, 1'b0, 2'd0, 1'b0);
        exp_state(4'b0001, 2'd1, 1'b0);
        idle();
        new_live(); exp_squash(4'b0001, 6'd1);
        step(1'b0, 2'd0, 6'd5, 1'b1, 2'd0, 1'b1);
        exp_state(4'b0000, 2'd0, 1'b0); exp_quiet();
        idle();

        // Fill all four checkpoints; rptr 10, 12, 0 (sum == size), 23.
        exp_state(4'b0000, 2'd0, 1'b0); step(1'b1, 2'd0, 6'd10, 1'b0, 2'd0, 1'b0);
        exp_state(4'b0001, 2'd1, 1'b0); step(1'b1, 2'd2, 6'd10, 1'b0, 2'd0, 1'b0);
        exp_state(4'b0011, 2'd2, 1'b0); step(1'b1, 2'd1, 6'd31, 1'b0, 2'd0, 1'b0);
        exp_state(4'b0111, 2'd3, 1'b0); step(1'b1, 2'd3, 6'd20, 1'b0, 2'd0, 1'b0);
        exp_state(4'b1111, 2'd0, 1'b1); step(1'b1, 2'd2, 6'd0, 1'b0, 2'd0, 1'b0);
        exp_state(4'b1111, 2'd0, 1'b1); exp_quiet();
        idle();

        // Mispredict tag 1 kills 1, 2, 3.
        new_live(); exp_squash(4'b1110, 6'd12);
        step(1'b0, 2'd0, 6'd9, 1'b1, 2'd1, 1'b1);
        exp_state(4'b0001, 2'd1, 1'b0);
        idle();

        // Rebuild, then correct-resolve tag 0 while dispatching tag 3.
        exp_state(4'b0001, 2'd1, 1'b0); step(1'b1, 2'd1, 6'd0, 1'b0, 2'd0, 1'b0);
        exp_state(4'b0011, 2'd2, 1'b0); step(1'b1, 2'd0, 6'd7, 1'b0, 2'd0, 1'b0);
        exp_state(4'b0111, 2'd3, 1'b0); exp_quiet();
        step(1'b1, 2'd2, 6'd15, 1'b1, 2'd0, 1'b0);
        exp_state(4'b1110, 2'd0, 1'b0); step(1'b1, 2'd0, 6'd25, 1'b0, 2'd0, 1'b0);

        // Reused tag 0 is youngest; no stale bit 0 may drag others into its squash.
        new_live(); exp_squash(4'b0001, 6'd25);
        step(1'b0, 2'd0, 6'd0, 1'b1, 2'd0, 1'b1);
        new_live(); exp_squash(4'b1100, 6'd7);
        step(1'b0, 2'd0, 6'd0, 1'b1, 2'd2, 1'b1);
        exp_state(4'b0010, 2'd0, 1'b0);
        idle();
        new_live(); exp_squash(4'b0010, 6'd1);
        step(1'b0, 2'd0, 6'd0, 1'b1, 2'd1, 1'b1);

        // Dispatch in the same cycle as a mispredict of the only live branch.
        exp_state(4'b0000, 2'd0, 1'b0); step(1'b1, 2'd1, 6'd3, 1'b0, 2'd0, 1'b0);
        new_live(); exp_squash(4'b0001, 6'd4);
        step(1'b1, 2'd2, 6'd8, 1'b1, 2'd0, 1'b1);
        exp_state(4'b0000, 2'd0, 1'b0); exp_quiet();
        idle();

        // Resolves on invalid tags are ignored.
        exp_quiet(); step(1'b0, 2'd0, 6'd0, 1'b1, 2'd2, 1'b1);
        exp_state(4'b0000, 2'd0, 1'b0); exp_quiet();
        step(1'b0, 2'd0, 6'd0, 1'b1, 2'd3, 1'b0);
        exp_state(4'b0000, 2'd0, 1'b0);
        idle();

        // Reset with three live entries, colliding with dispatch and mispredict.
        exp_state(4'b0000, 2'd0, 1'b0); step(1'b1, 2'd0, 6'd1, 1'b0, 2'd0, 1'b0);
        exp_state(4'b0001, 2'd1, 1'b0); step(1'b1, 2'd0, 6'd2, 1'b0, 2'd0, 1'b0);
        exp_state(4'b0011, 2'd2, 1'b0); step(1'b1, 2'd0, 6'd3, 1'b0, 2'd0, 1'b0);
        reset = 1'b1;
        exp_state(4'b0111, 2'd3, 1'b0);
        step(1'b1, 2'd1, 6'd1, 1'b1, 2'd0, 1'b1);
        exp_reset_outputs();
        idle();
        reset = 1'b0;
        exp_state(4'b0000, 2'd0, 1'b0); exp_quiet();
        step(1'b0, 2'd0, 6'd0, 1'b1, 2'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fl_checkpoint_stack.md
# fl_checkpoint_stack

Branch checkpoint controller for the physical-register freelist. It records the freelist read pointer when each branch dispatches and tracks branch age with dependency masks. When a branch resolves as mispredicted, it produces the squash strobe and the `FREELIST_STATE_PACKET` restore image the freelist loads that same cycle. It sits between dispatch, the branch functional unit and the freelist, and is the single source of `squash`/`branch_stack_state` for the freelist.

## Interface
- `DEPTH`, default 4: number of in-flight branch checkpoints.
- `FIFO_SIZE`, default `` `FREELIST_FIFO_SIZE`` (32): freelist ring size; sets pointer modulus.
- `clock`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `br_dispatch`, in, 1: a branch dispatches this cycle (at most one per cycle).
- `br_pregs_before`, in, 2: pregs taken from the freelist this cycle by bundle slots up to and including the branch (0..3, saturate 3).
- `fl_state_in`, in, `FREELIST_STATE_PACKET`: the freelist's `current_state_out`. Its `write_ptr` and `free_list` fields are next-state values; its `read_ptr` is the registered value.
- `resolve_valid`, in, 1: a branch resolves this cycle.
- `resolve_tag`, in, `$clog2(DEPTH)`: tag of the resolving branch.
- `resolve_mispredict`, in, 1: the resolving branch was mispredicted.
- `alloc_tag`, out, `$clog2(DEPTH)`: tag given to the dispatching branch.
- `alloc_mask`, out, `DEPTH`: live older-branch mask, for tagging the dispatching instructions.
- `stall`, out, 1: all checkpoints are in use; dispatch must not send a branch.
- `squash`, out, 1: freelist restore strobe.
- `branch_stack_state`, out, `FREELIST_STATE_PACKET`: restore image.
- `kill_mask`, out, `DEPTH`: tags invalidated by this squash, for ROB/RS flush.

## Operation
- Per entry i, registered: `valid[i]`, `rptr[i]` (`$clog2(FIFO_SIZE)+1` bits), `dep[i]` (`DEPTH` bits, the older live branches).
- Allocation:
  - `alloc_tag` is the lowest index with `valid==0`.
  - `stall = &valid`, computed from registered state only.
- On `br_dispatch & !stall & !mis_hit`, the next state of entry `alloc_tag` is:
  - `valid=1`;
  - `dep` = `valid` after this cycle's correct-resolve clear;
  - `rptr` = (`fl_state_in.read_ptr` + `br_pregs_before`), taking `−FIFO_SIZE` when the sum is ≥ `FIFO_SIZE`.
- `br_dispatch` while `stall` is a protocol error: ignore it, no state change.
- Correct resolve (`resolve_valid & !resolve_mispredict & valid[tag]`):
  - clear `valid[tag]`;
  - clear bit `tag` in every `dep[j]`.
- Mispredict (`mis_hit = resolve_valid & resolve_mispredict & valid[tag]`):
  - `kill_mask` = bit `tag` plus every j with `valid[j] & dep[j][tag]`;
  - clear `valid` for all of `kill_mask`;
  - `squash=1`;
  - `branch_stack_state.read_ptr = rptr[tag]`;
  - `branch_stack_state.write_ptr = fl_state_in.write_ptr`;
  - `branch_stack_state.free_list = fl_state_in.free_list`.
  - Live write side is kept because retirements are always older than the branch.
- Resolve on an invalid tag: ignored. `squash=0`, `kill_mask=0`.
- Simultaneous dispatch and mispredict: the mispredict wins and the dispatching branch is dropped, because it is younger. No allocation happens and `alloc_mask` is don't-care.
- Simultaneous dispatch and correct resolve: allowed. The freed tag is not reusable until next cycle. The new entry's `dep` excludes the resolved tag.

## Timing
- `squash`, `branch_stack_state` and `kill_mask` are combinational from the resolve inputs and registered state: 0-cycle latency. The freelist loads them at the same clock edge.
- `alloc_tag`, `alloc_mask` and `stall` come from registered state only.
- A new checkpoint is visible (resolvable) from the next cycle.
- Reset:
  - all `valid=0`, `dep=0`, `rptr=0`;
  - outputs: `stall=0`, `squash=0`, `kill_mask=0`, `alloc_tag=0`, `alloc_mask=0`, `branch_stack_state` = all zero.
- Reset has priority over resolve and dispatch in the same cycle and discards all checkpoints mid-operation.

## Structure
- Shared package `sys_defs`:
  - `` `BSTACK_DEPTH``;
  - `BRANCH_TAG` typedef;
  - `BRANCH_MASK` typedef;
  - existing `FREELIST_STATE_PACKET`.
- Sub-module `bstack_alloc_sel`: parameterized lowest-zero priority encoder. Outputs the index and an any-free flag.

## Test plan
- Reset, then dispatch a branch with `fl read_ptr=30` and `br_pregs_before=3`: tag 0 gets `rptr=1` (wrap), `stall=0`.
- Dispatch 4 branches on consecutive cycles: tags 0,1,2,3 with `dep` 0000,0001,0011,0111; `stall=1` after the 4th. A 5th `br_dispatch` changes nothing.
- With tags 0–3 live, mispredict tag 1: `squash=1` the same cycle, `kill_mask=1110`, `read_ptr=rptr[1]`, live `write_ptr`/`free_list` passed through. Next cycle `valid=0001`.
- Correct resolve of tag 0, then mispredict tag 2: `kill_mask=1100`, and `dep[2]` no longer holds bit 0.
- Same-cycle dispatch plus mispredict of tag 0 with tag 0 the only live entry: `squash=1`, `kill_mask=0001`, no allocation, `valid=0000` next cycle.
- Mispredict on an invalid tag, and reset asserted while 3 entries are live: respectively `squash=0` with no change, and all valid bits clear with outputs at reset values.
